// File: rtl/exp_result_collector_if.sv
// Result-stream bundle between the exp() evaluator, the result collector and its downstream reader.
// Direction names are from the collector's point of view; master is the driving/observing side.
interface exp_result_collector_if #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
);
    logic                  i_valid;
    logic [WIDTH-1:0]      i_y;
    logic                  o_ready;
    logic                  o_valid;
    logic [WIDTH-1:0]      o_y;
    logic                  i_ready;
    logic                  i_clear;
    logic [CNTW-1:0]       o_count;
    logic                  o_count_sat;
    logic [WIDTH+CNTW-1:0] o_sum;
    logic [WIDTH-1:0]      o_max;

    modport master (
        output i_valid, i_y, i_ready, i_clear,
        input  o_ready, o_valid, o_y, o_count, o_count_sat, o_sum, o_max
    );

    modport slave (
        input  i_valid, i_y, i_ready, i_clear,
        output o_ready, o_valid, o_y, o_count, o_count_sat, o_sum, o_max
    );
endinterface

// File: rtl/exp_result_collector.sv
// Buffers Q7.25 exp() results in a FWFT FIFO and keeps count/sum/max statistics of accepted samples.
// Latency: push visible at the head one cycle later; statistics registered on the accepting edge.
// Backpressure: o_ready decoded from registered occupancy only, low while the FIFO is full.
module exp_result_collector #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    exp_result_collector_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           occ;
    logic [CNTW-1:0]       count;
    logic                  count_sat;
    logic [WIDTH+CNTW-1:0] sum;
    logic [WIDTH-1:0]      max_y;
    logic                  push;
    logic                  pop;
    logic [CNTW-1:0]       count_inc;

    assign bus.o_ready     = (occ != FULL_OCC);
    assign bus.o_valid     = (occ != '0);
    assign bus.o_y         = mem[rd_ptr];
    assign bus.o_count     = count;
    assign bus.o_count_sat = count_sat;
    assign bus.o_sum       = sum;
    assign bus.o_max       = max_y;

    assign push      = bus.i_valid & bus.o_ready;
    assign pop       = bus.o_valid & bus.i_ready;
    assign count_inc = count + CNTW'(1);

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.i_y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                occ <= occ + (AW+1)'(1);
            end else if (pop && !push) begin
                occ <= occ - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            count_sat <= 1'b0;
            sum       <= '0;
            max_y     <= '0;
        end else if (bus.i_clear) begin
            // A push coinciding with clear becomes the first sample of the new window.
            count     <= push ? CNTW'(1) : '0;
            count_sat <= 1'b0;
            sum       <= push ? (WIDTH+CNTW)'(bus.i_y) : '0;
            max_y     <= push ? bus.i_y : '0;
        end else if (push) begin
            sum <= sum + (WIDTH+CNTW)'(bus.i_y);
            if (count != '1) begin
                count <= count_inc;
                if (count_inc == '1) begin
                    count_sat <= 1'b1;
                end
            end
            if (bus.i_y > max_y) begin
                max_y <= bus.i_y;
            end
        end
    end
endmodule

// File: tb/tb_exp_result_collector.sv
// Directed bench for exp_result_collector: FIFO order, backpressure, statistics, clear and async reset.
module tb_exp_result_collector;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    exp_result_collector_if #(.WIDTH(32), .CNTW(16)) bus_a ();
    exp_result_collector_if #(.WIDTH(32), .CNTW(2))  bus_b ();

    exp_result_collector #(.WIDTH(32), .DEPTH(4), .CNTW(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    exp_result_collector #(.WIDTH(32), .DEPTH(4), .CNTW(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        bus_a.i_clear = 1'b1;
        tick();
        bus_a.i_clear = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus_a.i_valid = 1'b0; bus_a.i_y = '0; bus_a.i_ready = 1'b0; bus_a.i_clear = 1'b0;
        bus_b.i_valid = 1'b0; bus_b.i_y = '0; bus_b.i_ready = 1'b0; bus_b.i_clear = 1'b0;
        #12;
        chk("rst_valid", 64'(bus_a.o_valid), 64'd0);
        chk("rst_ready", 64'(bus_a.o_ready), 64'd1);
        chk("rst_count", 64'(bus_a.o_count), 64'd0);
        chk("rst_sum",   64'(bus_a.o_sum),   64'd0);
        reset = 1'b1;
        #1;

        // Single sample: push at edge 1, pop at edge 2
        bus_a.i_valid = 1'b1; bus_a.i_y = 32'h0200_0000; bus_a.i_ready = 1'b1;
        tick();
        bus_a.i_valid = 1'b0;
        chk("one_valid", 64'(bus_a.o_valid), 64'd1);
        chk("one_y",     64'(bus_a.o_y),     64'h0200_0000);
        chk("one_count", 64'(bus_a.o_count), 64'd1);
        chk("one_sum",   64'(bus_a.o_sum),   64'h0200_0000);
        chk("one_max",   64'(bus_a.o_max),   64'h0200_0000);
        tick();
        chk("one_popped", 64'(bus_a.o_valid), 64'd0);

        // Fill and backpressure
        clear_a();
        chk("clr_count", 64'(bus_a.o_count), 64'd0);
        bus_a.i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus_a.i_valid = 1'b1; bus_a.i_y = 32'(k);
            tick();
            if (k == 3) chk("fill_ready3", 64'(bus_a.o_ready), 64'd1);
            if (k == 4) chk("fill_ready4", 64'(bus_a.o_ready), 64'd0);
        end
        bus_a.i_valid = 1'b0;
        chk("fill_count", 64'(bus_a.o_count), 64'd4);
        chk("fill_sum",   64'(bus_a.o_sum),   64'd10);
        chk("fill_max",   64'(bus_a.o_max),   64'd4);
        bus_a.i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_y", 64'(bus_a.o_y), 64'(k));
            tick();
            if (k == 1) chk("drain_ready", 64'(bus_a.o_ready), 64'd1);
        end
        chk("drain_empty", 64'(bus_a.o_valid), 64'd0);

        // Streaming push/pop across pointer wrap
        clear_a();
        bus_a.i_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus_a.i_y = 32'(100 + k);
            tick();
            chk("stream_y",     64'(bus_a.o_y),     64'(100 + k));
            chk("stream_ready", 64'(bus_a.o_ready), 64'd1);
        end
        bus_a.i_valid = 1'b0;
        chk("stream_count", 64'(bus_a.o_count), 64'd20);
        chk("stream_sum",   64'(bus_a.o_sum),   64'd2190);
        tick();
        chk("stream_empty", 64'(bus_a.o_valid), 64'd0);

        // Clear collisions with buffered data
        bus_a.i_ready = 1'b0;
        bus_a.i_valid = 1'b1; bus_a.i_y = 32'h11; tick();
        bus_a.i_y = 32'h22; tick();
        bus_a.i_valid = 1'b0;
        clear_a();
        chk("clr_cnt0",  64'(bus_a.o_count), 64'd0);
        chk("clr_sum0",  64'(bus_a.o_sum),   64'd0);
        chk("clr_max0",  64'(bus_a.o_max),   64'd0);
        chk("clr_head",  64'(bus_a.o_y),     64'h11);
        bus_a.i_valid = 1'b1; bus_a.i_y = 32'h7; bus_a.i_clear = 1'b1;
        tick();
        bus_a.i_valid = 1'b0; bus_a.i_clear = 1'b0;
        chk("clrpush_count", 64'(bus_a.o_count), 64'd1);
        chk("clrpush_sum",   64'(bus_a.o_sum),   64'd7);
        chk("clrpush_max",   64'(bus_a.o_max),   64'd7);
        bus_a.i_ready = 1'b1;
        chk("clr_pop0", 64'(bus_a.o_y), 64'h11); tick();
        chk("clr_pop1", 64'(bus_a.o_y), 64'h22); tick();
        chk("clr_pop2", 64'(bus_a.o_y), 64'h7);  tick();
        chk("clr_empty", 64'(bus_a.o_valid), 64'd0);

        // Max tracking and wide sum
        clear_a();
        bus_a.i_valid = 1'b1; bus_a.i_y = 32'hFFFF_FFFF;
        tick(); tick(); tick();
        bus_a.i_y = 32'h0;
        tick();
        bus_a.i_valid = 1'b0;
        chk("big_max",   64'(bus_a.o_max),   64'hFFFF_FFFF);
        chk("big_sum",   64'(bus_a.o_sum),   64'h2_FFFF_FFFD);
        chk("big_count", 64'(bus_a.o_count), 64'd4);
        tick();

        // Saturating counter on the narrow instance
        bus_b.i_valid = 1'b1; bus_b.i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus_b.i_y = 32'(k);
            tick();
            if (k == 2) chk("sat_early", 64'(bus_b.o_count_sat), 64'd0);
            if (k >= 3) begin
                chk("sat_count", 64'(bus_b.o_count),     64'd3);
                chk("sat_flag",  64'(bus_b.o_count_sat), 64'd1);
            end
        end
        bus_b.i_valid = 1'b0;
        chk("sat_sum", 64'(bus_b.o_sum), 64'd10);
        bus_b.i_clear = 1'b1; tick(); bus_b.i_clear = 1'b0;
        chk("sat_clr", 64'(bus_b.o_count_sat), 64'd0);

        // Asynchronous reset with three entries buffered
        bus_a.i_ready = 1'b0;
        bus_a.i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus_a.i_y = 32'(k + 1);
            tick();
        end
        bus_a.i_valid = 1'b0;
        chk("pre_rst_valid", 64'(bus_a.o_valid), 64'd1);
        #3 reset = 1'b0;
        #1;
        chk("arst_valid", 64'(bus_a.o_valid), 64'd0);
        chk("arst_ready", 64'(bus_a.o_ready), 64'd1);
        chk("arst_count", 64'(bus_a.o_count), 64'd0);
        chk("arst_sum",   64'(bus_a.o_sum),   64'd0);
        chk("arst_max",   64'(bus_a.o_max),   64'd0);
        #1 reset = 1'b1;
        bus_a.i_valid = 1'b1; bus_a.i_y = 32'h55; bus_a.i_ready = 1'b1;
        tick();
        bus_a.i_valid = 1'b0;
        chk("post_rst_y",     64'(bus_a.o_y),     64'h55);
        chk("post_rst_count", 64'(bus_a.o_count), 64'd1);
        tick();
        chk("post_rst_empty", 64'(bus_a.o_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exp_result_collector.md
# exp_result_collector

Output-side consumer for the Taylor-series exp() evaluator's result stream. Accepts Q7.25 results over the valid/ready handshake, buffers them in a small first-word-fall-through FIFO drained by a downstream reader, and keeps running statistics (sample count, sum, maximum) over the accepted stream. Its `o_ready` drives the evaluator's `i_ready`, so a full buffer stalls the evaluator pipeline in place.

## Interface
- `WIDTH`, 32: result width, Q7.25, treated as unsigned.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `CNTW`, 16: sample-counter width.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  producer result valid; already gated with our `o_ready` by the producer.
- `i_y`  in  WIDTH  producer result.
- `o_ready`  out  1  buffer can accept; connects to the evaluator's `i_ready`.
- `o_valid`  out  1  FIFO head valid (not empty).
- `o_y`  out  WIDTH  FIFO head data.
- `i_ready`  in  1  downstream reader takes the head.
- `i_clear`  in  1  single-cycle pulse that clears the statistics.
- `o_count`  out  CNTW  accepted samples since reset or clear; saturating.
- `o_count_sat`  out  1  sticky: `o_count` reached all-ones.
- `o_sum`  out  WIDTH+CNTW  sum of accepted samples, modulo 2^(WIDTH+CNTW).
- `o_max`  out  WIDTH  largest accepted sample (unsigned).

## Operation
- Push when `i_valid & o_ready`. Pop when `o_valid & i_ready`.
- `o_ready = (occupancy != DEPTH)`. It is decoded from registered occupancy only, so there is no combinational path from `i_ready` to `o_ready`.
- FIFO storage:
  - Write pointer and read pointer are each log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is log2(DEPTH)+1 bits.
  - `o_y = mem[rd_ptr]` and `o_valid = (occupancy != 0)`.
- Occupancy update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged; both pointers advance.
  - When full, only a pop is possible. When empty, only a push is possible.
- `o_y` holds stable while `o_valid & !i_ready`.
- Statistics update on each push:
  - `o_sum += zero-extended i_y`, wrapping.
  - `o_count += 1`, saturating at 2^CNTW−1. `o_count_sat` sets on reaching that value and stays set.
  - `o_max` updates when `i_y > o_max`.
- `i_clear` without push: `o_count`, `o_sum`, `o_max` and `o_count_sat` go to 0 on the next edge.
- `i_clear` with push in the same cycle: statistics restart with that sample, giving `o_count=1`, `o_sum=i_y`, `o_max=i_y` and `o_count_sat=0`.
- `i_clear` never affects FIFO contents or pointers.
- Reset (`reset=0`), immediate and asynchronous:
  - Pointers, occupancy and all statistics go to 0.
  - `o_valid=0` and `o_ready=1`.
  - Stored data is discarded. Memory contents need not be cleared.
- Reset asserted mid-stream drops all buffered entries and statistics. There is no partial state.

## Timing
- Push-to-`o_valid` latency: 1 cycle. A push at edge N gives `o_valid=1` and the head data after edge N.
- Statistics reflect a push from the edge on which it is accepted; they are registered outputs.
- Full throughput: with `i_ready` held high, one push and one pop per cycle and occupancy stays constant.
- From full, a pop at edge N raises `o_ready` after edge N. The producer's next transfer is at edge N+1 at the earliest.
- After `reset` deasserts, a push is accepted on the first rising edge.

## Test plan
- Reset then single sample:
  - Stimulus: push `i_y=32'h0200_0000` (1.0) at edge 1, with `i_ready=1`.
  - Required: `o_valid=1` and `o_y=32'h0200_0000` after edge 1; pop at edge 2.
  - Required after edge 1: `o_count=1`, `o_sum=32'h0200_0000`, `o_max=32'h0200_0000`.
- Fill and backpressure:
  - Stimulus: `i_ready=0`, push 5 consecutive values 1..5.
  - Required: `o_ready` drops after the 4th push; the 5th is not accepted; `o_count=4`.
  - Then: raise `i_ready`. Required: pops return 1,2,3,4 in order; `o_ready` returns high after the first pop.
- Simultaneous push/pop with wrap:
  - Stimulus: hold `i_valid=i_ready=1` for 20 cycles with incrementing data.
  - Required: occupancy stays at 1; output order matches input order across pointer wrap; `o_count=20`; `o_sum` equals the arithmetic sum.
- Clear collisions:
  - Stimulus: `i_clear` alone.
  - Required: statistics are 0 next cycle and FIFO occupancy is unchanged.
  - Stimulus: `i_clear` with a push of `32'h0000_0007`.
  - Required: `o_count=1`, `o_sum=7`, `o_max=7`.
- Max tracking and sum wrap:
  - Stimulus: push `32'hFFFF_FFFF` 3 times, then 0.
  - Required: `o_max=32'hFFFF_FFFF`; `o_sum=48'h2_FFFF_FFFD`.
  - Stimulus: with `CNTW=2`, push 4 samples.
  - Required: `o_count` holds at 3 and `o_count_sat=1`.
- Reset mid-operation:
  - Stimulus: assert `reset` asynchronously between edges with 3 entries buffered.
  - Required: `o_valid=0`, `o_ready=1` and statistics 0 immediately, without waiting for an edge; the first post-reset push is the only entry popped.
